// File: rtl/apb_controller_pkg.sv
// Shared definitions for the AHB-to-APB bridge: widths, AHB constants and
// the APB controller state encoding.
package apb_controller_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned SelW  = 3;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic [1:0] HrespOkay  = 2'b00;
  localparam logic [1:0] HrespError = 2'b01;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWwait   = 3'd1,
    StRsetup  = 3'd2,
    StWsetup  = 3'd3,
    StRenable = 3'd4,
    StWenable = 3'd5
  } apb_state_e;

  // AHB may present a new transfer only in states that end the data phase.
  function automatic logic state_ready(apb_state_e st);
    return (st == StIdle) || (st == StRenable) || (st == StWenable);
  endfunction

endpackage

// File: rtl/apb_controller_if.sv
// AHB-side and APB-side signals of the bridge controller. The master modport
// is the controller itself; the slave modport is its environment.
interface apb_controller_if;
  import apb_controller_pkg::*;

  logic             valid;
  logic [AddrW-1:0] Haddr;
  logic             Hwrite;
  logic [SelW-1:0]  tempselx;
  logic [DataW-1:0] Hwdata;
  logic [DataW-1:0] Prdata;

  logic             Pwrite;
  logic [SelW-1:0]  Pselx;
  logic             Penable;
  logic [AddrW-1:0] Paddr;
  logic [DataW-1:0] Pwdata;
  logic             Hreadyout;
  logic [DataW-1:0] Hrdata;
  logic [1:0]       Hresp;

  modport master (
    input  valid, Haddr, Hwrite, tempselx, Hwdata, Prdata,
    output Pwrite, Pselx, Penable, Paddr, Pwdata, Hreadyout, Hrdata, Hresp
  );

  modport slave (
    output valid, Haddr, Hwrite, tempselx, Hwdata, Prdata,
    input  Pwrite, Pselx, Penable, Paddr, Pwdata, Hreadyout, Hrdata, Hresp
  );

endinterface

// File: rtl/apb_controller.sv
// APB master FSM of the AHB-to-APB bridge: one setup and one enable phase per
// accepted AHB transfer, with Hreadyout stretching the AHB data phase.
module apb_controller
  import apb_controller_pkg::*;
(
  input  logic                Hclk,
  input  logic                Hreset,
  apb_controller_if.master    bridge_io
);

  apb_state_e       state_q, state_d;
  logic [SelW-1:0]  selx_q, selx_d;
  logic [SelW-1:0]  pselx_q, pselx_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [AddrW-1:0] paddr_q, paddr_d;
  logic [DataW-1:0] pwdata_q, pwdata_d;
  logic             ready;
  logic             accept;

  assign ready  = state_ready(state_q);
  assign accept = ready && bridge_io.valid && (bridge_io.tempselx != '0);

  always_comb begin
    state_d  = state_q;
    selx_d   = selx_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    unique case (state_q)
      StIdle, StRenable, StWenable: begin
        if (accept) begin
          state_d  = bridge_io.Hwrite ? StWwait : StRsetup;
          selx_d   = bridge_io.tempselx;
          pwrite_d = bridge_io.Hwrite;
          paddr_d  = bridge_io.Haddr;
        end else begin
          state_d = StIdle;
        end
      end
      StWwait: begin
        pwdata_d = bridge_io.Hwdata;
        state_d  = StWsetup;
      end
      StRsetup: state_d = StRenable;
      StWsetup: state_d = StWenable;
      default:  state_d = StIdle;
    endcase

    // APB strobes are registered, so derive them from the state being entered.
    pselx_d   = '0;
    penable_d = 1'b0;
    unique case (state_d)
      StRsetup, StWsetup:   pselx_d = selx_d;
      StRenable, StWenable: begin
        pselx_d   = selx_d;
        penable_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q   <= StIdle;
      selx_q    <= '0;
      pselx_q   <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      selx_q    <= selx_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign bridge_io.Pselx     = pselx_q;
  assign bridge_io.Penable   = penable_q;
  assign bridge_io.Pwrite    = pwrite_q;
  assign bridge_io.Paddr     = paddr_q;
  assign bridge_io.Pwdata    = pwdata_q;
  assign bridge_io.Hreadyout = ready;
  assign bridge_io.Hrdata    = (state_q == StRenable) ? bridge_io.Prdata : '0;
  assign bridge_io.Hresp     = HrespOkay;

endmodule
